im2col_addr_gen: RTL and testbench

- Sequential im2col read-address generator for the SCNN ifmap GLB; consumes the per-layer shape/jump values produced by the shape-info compiler.
- For every output pixel (one im2col vector), emits the ifmap addresses of the receptive field across all channels; the downstream CSC encoder / GLB read port consumes them.
- Each address is paired with a vector index (psum row address) and vector/last tags via a valid/ready stream.

---
 rtl/im2col_addr_gen_pkg.sv | 19 +
 rtl/im2col_addr_gen_if.sv | 17 +
 rtl/im2col_nested_counter.sv | 53 +++++
 rtl/im2col_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_im2col_addr_gen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/im2col_addr_gen_pkg.sv
// Shared types and constants for the im2col read-address generator.
package im2col_addr_gen_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned VEC_W_DEF  = 10;
  localparam int unsigned MAX_FILTER = 7;
  localparam int unsigned FILTER_W   = $clog2(MAX_FILTER + 1);

  // Odometer geometry: level 0 = kx (innermost) ... level 4 = oy (outermost).
  localparam int unsigned LEVELS = 5;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/im2col_addr_gen_if.sv
// Address stream from the im2col generator to the CSC encoder / GLB read port.
interface im2col_addr_gen_if
  import im2col_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned VEC_W  = VEC_W_DEF
);
  logic [ADDR_W-1:0] addr;
  logic [VEC_W-1:0]  vec_idx;
  logic              last_in_vec;
  logic              last;
  logic              addr_valid;
  logic              addr_ready;

  modport master (output addr, vec_idx, last_in_vec, last, addr_valid, input addr_ready);
  modport slave  (input addr, vec_idx, last_in_vec, last, addr_valid, output addr_ready);
endinterface

// File: rtl/im2col_nested_counter.sv
// Five-level odometer (kx, ky, ch, ox, oy); bounds latched on load, per-level
// registered at-max flags double as the wrap indication for the next advance.
module im2col_nested_counter
  import im2col_addr_gen_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         advance,
  input  logic [LEVELS-1:0][CNT_W-1:0] bound,
  output logic [LEVELS-1:0]            at_max
);

  logic [LEVELS-1:0][CNT_W-1:0] cnt;
  logic [LEVELS-1:0][CNT_W-1:0] bound_q;
  logic [LEVELS-1:0]            carry;

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 1; i < LEVELS; i++) begin
      carry[i] = carry[i-1] & at_max[i-1];
    end
  end

  // at_max is looked ahead one step so it is valid in the same cycle as the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bound_q <= '0;
      at_max  <= '0;
    end else if (load) begin
      bound_q <= bound;
      cnt     <= '0;
      for (int unsigned i = 0; i < LEVELS; i++) begin
        at_max[i] <= (bound[i] == CNT_W'(1));
      end
    end else if (advance) begin
      for (int unsigned i = 0; i < LEVELS; i++) begin
        if (carry[i]) begin
          if (at_max[i]) begin
            cnt[i]    <= '0;
            at_max[i] <= (bound_q[i] == CNT_W'(1));
          end else begin
            cnt[i]    <= cnt[i] + CNT_W'(1);
            at_max[i] <= (({1'b0, cnt[i]} + (CNT_W+1)'(2)) == {1'b0, bound_q[i]});
          end
        end
      end
    end
  end

endmodule

// File: rtl/im2col_addr_gen.sv
// Sequential im2col ifmap read-address generator (oy, ox, ch, ky, kx loop order).
// Optional IM2COL_STALL_CNT_EN adds a saturating stall_cnt output.
module im2col_addr_gen
  import im2col_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned VEC_W  = VEC_W_DEF
)(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          ifmap_len,
  input  logic [4:0]          ofmap_size,
  input  logic [FILTER_W-1:0] filter_size,
  input  logic [9:0]          channels,
  input  logic [ADDR_W-1:0]   ch_stride,
  input  logic [ADDR_W-1:0]   base_addr,
  im2col_addr_gen_if.master   stream,
  output logic                busy,
  output logic                done
`ifdef IM2COL_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] len_q, stride_q;
  logic [ADDR_W-1:0] oy_ptr, vec_ptr, ch_ptr, row_ptr, addr_q;
  logic [ADDR_W-1:0] oy_n, vec_n, ch_n, row_n, addr_n;
  logic [VEC_W-1:0]  idx_q, idx_n;
  logic              valid_q;

  logic [LEVELS-1:0]            at_max;
  logic [LEVELS-1:0][CNT_W-1:0] bound;
  logic                         accept, degenerate, xfer, last_beat, liv;

  assign degenerate = (ofmap_size == '0) || (filter_size == '0) || (channels == '0);
  assign accept     = (state_q == ST_IDLE) && start;
  assign xfer       = valid_q && stream.addr_ready;
  assign last_beat  = &at_max;
  assign bound      = {CNT_W'(ofmap_size), CNT_W'(ofmap_size), CNT_W'(channels),
                       CNT_W'(filter_size), CNT_W'(filter_size)};

  im2col_nested_counter u_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .advance (xfer),
    .bound   (bound),
    .at_max  (at_max)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = degenerate ? ST_DONE : ST_RUN;
      ST_RUN:  if (xfer && last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each pointer holds the address of its loop's origin; the lowest level that
  // does not wrap advances, and every finer pointer restarts from it.
  always_comb begin
    oy_n   = oy_ptr;
    vec_n  = vec_ptr;
    ch_n   = ch_ptr;
    row_n  = row_ptr;
    addr_n = addr_q;
    idx_n  = idx_q;
    if (!at_max[0]) begin
      addr_n = addr_q + ADDR_W'(1);
    end else if (!at_max[1]) begin
      row_n  = row_ptr + len_q;
      addr_n = row_n;
    end else if (!at_max[2]) begin
      ch_n   = ch_ptr + stride_q;
      row_n  = ch_n;
      addr_n = ch_n;
    end else if (!at_max[3]) begin
      vec_n  = vec_ptr + ADDR_W'(1);
      ch_n   = vec_n;
      row_n  = vec_n;
      addr_n = vec_n;
      idx_n  = idx_q + VEC_W'(1);
    end else begin
      oy_n   = oy_ptr + len_q;
      vec_n  = oy_n;
      ch_n   = oy_n;
      row_n  = oy_n;
      addr_n = oy_n;
      idx_n  = idx_q + VEC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      stride_q <= '0;
      oy_ptr   <= '0;
      vec_ptr  <= '0;
      ch_ptr   <= '0;
      row_ptr  <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_d == ST_RUN);
      done <= (state_d == ST_DONE);
      if (accept) begin
        len_q    <= ADDR_W'(ifmap_len);
        stride_q <= ch_stride;
        oy_ptr   <= base_addr;
        vec_ptr  <= base_addr;
        ch_ptr   <= base_addr;
        row_ptr  <= base_addr;
        addr_q   <= base_addr;
        idx_q    <= '0;
        valid_q  <= !degenerate;
      end else if (xfer) begin
        if (last_beat) begin
          valid_q <= 1'b0;
        end else begin
          oy_ptr  <= oy_n;
          vec_ptr <= vec_n;
          ch_ptr  <= ch_n;
          row_ptr <= row_n;
          addr_q  <= addr_n;
          idx_q   <= idx_n;
        end
      end
    end
  end

  assign liv                = valid_q && (&at_max[2:0]);
  assign stream.addr        = addr_q;
  assign stream.vec_idx     = idx_q;
  assign stream.addr_valid  = valid_q;
  assign stream.last_in_vec = liv;
  assign stream.last        = liv && (&at_max[4:3]);

`ifdef IM2COL_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (valid_q && !stream.addr_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_im2col_addr_gen.sv
// Scoreboard bench for im2col_addr_gen: nested-loop reference model feeds a
// queue, a negedge monitor compares every presented beat against its head.
module tb_im2col_addr_gen;
  import im2col_addr_gen_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  ifmap_len = '0;
  logic [4:0]  ofmap_size = '0;
  logic [2:0]  filter_size = '0;
  logic [9:0]  channels = '0;
  logic [13:0] ch_stride = '0;
  logic [13:0] base_addr = '0;
  logic        busy, done;
`ifdef IM2COL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  im2col_addr_gen_if #(.ADDR_W(14), .VEC_W(10)) sif ();

  im2col_addr_gen #(.ADDR_W(14), .VEC_W(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .ifmap_len   (ifmap_len),
    .ofmap_size  (ofmap_size),
    .filter_size (filter_size),
    .channels    (channels),
    .ch_stride   (ch_stride),
    .base_addr   (base_addr),
    .stream      (sif),
    .busy        (busy),
    .done        (done)
`ifdef IM2COL_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [9:0]  idx;
    logic        liv;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned pop_cyc = 0;
  bit          pat[0:4095];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    beat_t act;
    forever begin
      @(negedge clock);
      if (sif.addr_valid === 1'b1) begin
        act = {sif.addr, sif.vec_idx, sif.last_in_vec, sif.last};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got addr=%0d vec=%0d with none expected", sif.addr, sif.vec_idx);
        end else begin
          if (act !== exp_q[0]) begin
            errors++;
            $display("FAIL beat: got addr=%0d vec=%0d liv=%0b last=%0b expected addr=%0d vec=%0d liv=%0b last=%0b",
                     act.addr, act.idx, act.liv, act.last,
                     exp_q[0].addr, exp_q[0].idx, exp_q[0].liv, exp_q[0].last);
          end
          if (sif.addr_ready === 1'b1) begin
            void'(exp_q.pop_front());
            pops++;
            pop_cyc = cyc;
          end
        end
        chk("busy_while_valid", 32'(busy), 32'd1);
      end
    end
  end

  task automatic drive_cfg(input int len, input int ofs, input int fs, input int ch,
                           input int stride, input int base);
    ifmap_len   = 10'(len);
    ofmap_size  = 5'(ofs);
    filter_size = 3'(fs);
    channels    = 10'(ch);
    ch_stride   = 14'(stride);
    base_addr   = 14'(base);
  endtask

  task automatic scramble_cfg();
    drive_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // mode 0: ready always high; 1: ready 1,0,0,1 repeating; 2: random ready,
  // config scrambled and spurious start pulses during the run.
  task automatic run_cfg(input int len, input int ofs, input int fs, input int ch,
                         input int stride, input int base, input int mode, input int abort_after);
    beat_t b;
    int    n;
    int    k;
    int    ones;
    int    exp_stall;
    bit    done_seen;
    n = 0;
    for (int oy = 0; oy < ofs; oy++)
      for (int ox = 0; ox < ofs; ox++)
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < fs; ky++)
            for (int kx = 0; kx < fs; kx++) begin
              b.addr = 14'(base + c * stride + (oy + ky) * len + ox + kx);
              b.idx  = 10'(oy * ofs + ox);
              b.liv  = (c == ch - 1) && (ky == fs - 1) && (kx == fs - 1);
              b.last = b.liv && (oy == ofs - 1) && (ox == ofs - 1);
              exp_q.push_back(b);
              n++;
            end
    for (int i = 0; i < 4096; i++) begin
      case (mode)
        0:       pat[i] = 1'b1;
        1:       pat[i] = (i % 4 == 0) || (i % 4 == 3);
        default: pat[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
    ones = 0;
    exp_stall = 0;
    for (int i = 0; i < 4096 && ones < n; i++) begin
      if (pat[i]) ones++;
      else        exp_stall++;
    end

    @(posedge clock); #1;
    drive_cfg(len, ofs, fs, ch, stride, base);
    start = 1'b1;
    sif.addr_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    sif.addr_ready = pat[0];
    if (mode == 2) scramble_cfg();
    if (n > 0) chk("first_valid_latency", 32'(sif.addr_valid), 32'd1);

    done_seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (n == 0) chk("busy_degenerate", 32'(busy), 32'd0);
      if (done === 1'b1) begin
        done_seen = 1'b1;
        if (n == 0) chk("done_latency_degenerate", 32'(c <= 1), 32'd1);
        else        chk("done_after_last", cyc, pop_cyc + 1);
        break;
      end
      if (abort_after > 0 && pops >= abort_after) break;
      @(posedge clock); #1;
      k++;
      sif.addr_ready = pat[k];
      start = 1'b0;
      if (mode == 2) begin
        scramble_cfg();
        start = ($urandom_range(0, 7) == 0) && (exp_q.size() > 2);
      end
    end
    start = 1'b0;

    if (abort_after > 0) begin
      @(posedge clock); #1;
      reset = 1'b0;
      sif.addr_ready = 1'b1;
      #1;
      chk("reset_valid", 32'(sif.addr_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (3) begin
        @(negedge clock);
        chk("no_stale_done", 32'(done), 32'd0);
        chk("idle_after_reset", 32'(sif.addr_valid), 32'd0);
      end
      return;
    end

    chk("done_seen", 32'(done_seen), 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    @(negedge clock);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("valid_after_done", 32'(sif.addr_valid), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
`ifdef IM2COL_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
    exp_q.delete();
  endtask

  initial begin
    sif.addr_ready = 1'b0;
    #12;
    chk("rst_addr", 32'(sif.addr), 32'd0);
    chk("rst_vec_idx", 32'(sif.vec_idx), 32'd0);
    chk("rst_valid", 32'(sif.addr_valid), 32'd0);
    chk("rst_last_in_vec", 32'(sif.last_in_vec), 32'd0);
    chk("rst_last", 32'(sif.last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef IM2COL_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clock); #1;
    reset = 1'b1;

    run_cfg(4, 2, 3, 1, 0, 0, 0, 0);
    run_cfg(4, 2, 3, 2, 16, 0, 0, 0);
    run_cfg(4, 2, 3, 1, 0, 0, 1, 0);
    run_cfg(4, 4, 1, 1, 0, 100, 0, 0);
    run_cfg(4, 0, 3, 1, 0, 0, 0, 0);
    run_cfg(4, 2, 0, 1, 0, 0, 0, 0);
    run_cfg(4, 2, 3, 1, 0, 0, 0, 5);
    run_cfg(4, 2, 3, 1, 0, 0, 0, 0);
    run_cfg(9, 1, 7, 1, 0, 16380, 2, 0);
    for (int r = 0; r < 6; r++) begin
      run_cfg($urandom_range(0, 1023), $urandom_range(1, 4), $urandom_range(1, 3),
              $urandom_range(1, 3), $urandom_range(0, 16383), $urandom_range(0, 16383), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
